// File: rtl/mcycle_unit_if.sv
// Request/response bundle between the execute-stage control and the multi-cycle
// multiply/divide unit.
//   start        request, sampled only while the unit is idle
//   mcycle_op    00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div
//   operand1/2   multiplicand/dividend and multiplier/divisor
//   result1/2    mul: product low/high halves; div: quotient/remainder
//   busy         operation in flight (pipeline stalls on this)
//   done         one-cycle completion pulse
//   div_by_zero  divisor was zero; valid with done, held until next accept
interface mcycle_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       mcycle_op;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [WIDTH-1:0] result1;
  logic [WIDTH-1:0] result2;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, mcycle_op, operand1, operand2,
    input  result1, result2, busy, done, div_by_zero
  );

  modport slave (
    input  start, mcycle_op, operand1, operand2,
    output result1, result2, busy, done, div_by_zero
  );
endinterface

// File: rtl/mcycle_unit.sv
// Multi-cycle multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per clock, with sign correction on the final cycle.
//   clk  clock, rising edge
//   rst  asynchronous active-high reset; aborts any operation in flight
//   bus  slave side of mcycle_unit_if (start/op/operands in, results/busy/done out)
// Done rises WIDTH+1 clocks after the accepting edge; results hold until the next finish.
module mcycle_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  mcycle_unit_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCompute, StFinish} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [1:0]             op_q, op_d;
  logic                   sign1_q, sign1_d, sign2_q, sign2_d;
  logic [WIDTH-1:0]       opa_q, opa_d;   // raw dividend, returned on divide-by-zero
  logic [WIDTH-1:0]       mag2_q, mag2_d;
  // mul: {hi, lo} product/multiplier register; div: low half shifts dividend out, quotient in
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH:0]         rem_q, rem_d;
  logic [WIDTH-1:0]       res1_q, res1_d, res2_q, res2_d;
  logic                   busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  // Operand magnitudes at accept. Two's-complement negation of the most-negative value
  // yields 2^(WIDTH-1), which is exact when read as unsigned.
  logic             neg1, neg2;
  logic [WIDTH-1:0] mag1;
  always_comb begin
    neg1 = bus.mcycle_op[0] & bus.operand1[WIDTH-1];
    neg2 = bus.mcycle_op[0] & bus.operand2[WIDTH-1];
    mag1 = neg1 ? -bus.operand1 : bus.operand1;
  end

  // One shift-add multiply step.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag2_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // One restoring divide step; the extra top bit of the trial difference is the borrow.
  logic [WIDTH+1:0] div_shift, div_trial;
  logic             div_borrow;
  always_comb begin
    div_shift  = {rem_q, acc_q[WIDTH-1]};
    div_trial  = div_shift - {2'b00, mag2_q};
    div_borrow = div_trial[WIDTH+1];
  end

  // Sign-corrected results, used only in StFinish.
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
  always_comb begin
    prod_s = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
    quo_s  = (sign1_q ^ sign2_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s  = sign1_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sign1_d = sign1_q;
    sign2_d = sign2_q;
    opa_d   = opa_q;
    mag2_d  = mag2_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    busy_d  = busy_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d    = bus.mcycle_op;
          sign1_d = neg1;
          sign2_d = neg2;
          opa_d   = bus.operand1;
          mag2_d  = neg2 ? -bus.operand2 : bus.operand2;
          acc_d   = {{WIDTH{1'b0}}, mag1};
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
          state_d = StCompute;
        end
      end
      StCompute: begin
        if (op_q[1]) begin
          rem_d = div_borrow ? div_shift[WIDTH:0] : div_trial[WIDTH:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_borrow};
        end else begin
          acc_d = mul_next;
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFinish;
      end
      StFinish: begin
        if (!op_q[1]) begin
          res1_d = prod_s[WIDTH-1:0];
          res2_d = prod_s[2*WIDTH-1:WIDTH];
        end else if (mag2_q == '0) begin
          res1_d = '1;
          res2_d = opa_q;
          dbz_d  = 1'b1;
        end else begin
          res1_d = quo_s;
          res2_d = rem_s;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      opa_q   <= '0;
      mag2_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      opa_q   <= opa_d;
      mag2_q  <= mag2_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.result1     = res1_q;
  assign bus.result2     = res2_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule
